// File: rtl/countdown_timer_ctrl_pkg.sv
// Shared constants for the countdown timer: state encoding and board defaults.
package timer_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // 1 s tick on the 50 MHz board clock
  localparam int DEFAULT_TICK_DIV = 50_000_000;
  localparam int DEFAULT_TIME_W   = 10;

endpackage

// File: rtl/countdown_timer_ctrl_tick_prescaler.sv
// Tick prescaler: counts enabled cycles and pulses tick on the last count of each period.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             at_last;

  assign at_last = (cnt == LAST);
  assign tick    = en && at_last;

  // Holding while en is low is what preserves a partial second across pause.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Countdown timer controller: load/start/pause/clear FSM driving a seconds counter from a tick enable.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int TIME_W   = DEFAULT_TIME_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [TIME_W-1:0] load_value,
  input  logic              start,
  input  logic              pause,
  output logic [TIME_W-1:0] remaining,
  output logic [1:0]        state,
  output logic              tick,
  output logic              expired,
  output logic              expire_pulse
);

  logic [1:0]        state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic              pulse_q;
  logic              cnt_clr;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (state_q == ST_RUN),
    .clr  (cnt_clr),
    .tick (tick)
  );

  // Priority: clear, then load, then pause, then start. Commands with no
  // meaning in the current state are dropped so lower ones can still act.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_clr = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      rem_d   = '0;
      cnt_clr = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (load) begin
            rem_d   = load_value;
            cnt_clr = 1'b1;
          end else if (start) begin
            cnt_clr = 1'b1;
            state_d = (rem_q != '0) ? ST_RUN : ST_DONE;
          end
        end
        ST_RUN: begin
          // Expiry beats a coincident pause.
          if (tick && rem_q == TIME_W'(1)) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            if (tick && rem_q != '0) rem_d = rem_q - 1'b1;
            if (pause) state_d = ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (start) state_d = ST_RUN;
        end
        ST_DONE: begin
          if (load) begin
            rem_d   = load_value;
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pulse_q <= (state_d == ST_DONE) && (state_q != ST_DONE);
    end
  end

  assign state        = state_q;
  assign remaining    = rem_q;
  assign expired      = (state_q == ST_DONE);
  assign expire_pulse = pulse_q;

endmodule
